// File: rtl/data_ram_arbiter.sv
// Shares one single-port synchronous data RAM between two MIPS-side masters (m0 = LSU, m1 = aux loader).
// Latency: fixed 2 cycles from the sampled req to the ack pulse (IDLE -> ACCESS -> RESP), errors included.
// Backpressure: one access in flight; req is only sampled in IDLE, so a losing or early master simply waits.
//
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   mX_req/we/addr/wdata : request from master X (held until mX_ack)
//   mX_ack/err/rdata     : one-cycle completion, error flag and load data (err/rdata hold until next ack)
//   ram_en/we/addr/wdata : RAM strobe, write strobe, word index and write data
//   ram_rdata            : RAM read data, valid the cycle after ram_en
//   busy                 : FSM is not in IDLE
//   err_count            : saturating count of rejected accesses
//
// Build option: define DATA_RAM_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous
// requests; without it m0 has fixed priority over m1.

module data_ram_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h10010000,
    parameter int                    RAM_AW     = 10
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  ram_en,
    output logic                  ram_we,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,

    output logic                  busy,
    output logic [7:0]            err_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Byte span of the RAM: (offset >> 2) >= 2^RAM_AW is the same test as
    // offset >= 2^(RAM_AW+2), which lets the whole offset take part in the compare.
    localparam logic [ADDR_WIDTH-1:0] LP_SPAN =
        {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << (RAM_AW + 2);

    state_t                  r_state;
    state_t                  w_next_state;

    // Latched request (captured in IDLE, used in ACCESS/RESP)
    logic                    r_gnt;          // 0 = m0, 1 = m1
    logic                    r_we;
    logic [RAM_AW-1:0]       r_index;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_err;

    // Per-master response holding registers
    logic                    r_m0_err;
    logic [DATA_WIDTH-1:0]   r_m0_rdata;
    logic                    r_m1_err;
    logic [DATA_WIDTH-1:0]   r_m1_rdata;

    logic [7:0]              r_err_count;

    // Request selection / address checks
    logic                    w_any_req;
    logic                    w_gnt;
    logic                    w_sel_we;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;
    logic [ADDR_WIDTH-1:0]   w_offset;
    logic                    w_misaligned;
    logic                    w_out_of_range;
    logic [RAM_AW-1:0]       w_index;

    logic                    w_m0_ack;
    logic                    w_m1_ack;
    logic [DATA_WIDTH-1:0]   w_resp_rdata;

`ifdef DATA_RAM_ARB_ROUND_ROBIN_EN
    logic                    r_last_grant;   // 0 = m0, 1 = m1; reset to 1 so m0 wins the first tie
`endif

    //------------------------------------------------------------------
    // Arbitration
    //------------------------------------------------------------------
    assign w_any_req = m0_req | m1_req;

`ifdef DATA_RAM_ARB_ROUND_ROBIN_EN
    // On a tie give the grant to whoever did not get the last one;
    // otherwise the lone requester wins.
    assign w_gnt = (m0_req && m1_req) ? ~r_last_grant : ~m0_req;
`else
    // Fixed priority: m1 only when m0 is not asking.
    assign w_gnt = ~m0_req;
`endif

    assign w_sel_we    = w_gnt ? m1_we    : m0_we;
    assign w_sel_addr  = w_gnt ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_gnt ? m1_wdata : m0_wdata;

    //------------------------------------------------------------------
    // Address translation and checks. The subtraction wraps, so any
    // address below BASE_ADDR lands on a huge offset and fails the range test.
    //------------------------------------------------------------------
    assign w_offset       = w_sel_addr - BASE_ADDR;
    assign w_misaligned   = (w_sel_addr[1:0] != 2'b00);
    assign w_out_of_range = (w_offset >= LP_SPAN);
    assign w_index        = w_offset[RAM_AW+1:2];

    //------------------------------------------------------------------
    // FSM state register
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    //------------------------------------------------------------------
    // FSM next state and RAM / ack outputs
    //------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        w_m0_ack     = 1'b0;
        w_m1_ack     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_ACCESS;
                end
            end

            S_ACCESS: begin
                // A rejected access never touches the RAM, but still
                // walks through RESP so the latency is constant.
                if (!r_err) begin
                    ram_en    = 1'b1;
                    ram_we    = r_we;
                    ram_addr  = r_index;
                    ram_wdata = r_wdata;
                end
                w_next_state = S_RESP;
            end

            S_RESP: begin
                w_m0_ack     = ~r_gnt;
                w_m1_ack     = r_gnt;
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Only a good load returns RAM data; stores and rejected accesses return zero.
    assign w_resp_rdata = (r_we || r_err) ? '0 : ram_rdata;

    //------------------------------------------------------------------
    // Request latch, error counter and response holding registers
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt       <= 1'b0;
            r_we        <= 1'b0;
            r_index     <= '0;
            r_wdata     <= '0;
            r_err       <= 1'b0;
            r_err_count <= 8'h00;
            r_m0_err    <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_err    <= 1'b0;
            r_m1_rdata  <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_gnt   <= w_gnt;
                r_we    <= w_sel_we;
                r_index <= w_index;
                r_wdata <= w_sel_wdata;
                r_err   <= w_misaligned | w_out_of_range;
            end

            // Counted on leaving ACCESS so the count already includes this
            // error when the ack is seen; an access aborted by reset is not counted.
            if (r_state == S_ACCESS && r_err && r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end

            if (w_m0_ack) begin
                r_m0_err   <= r_err;
                r_m0_rdata <= w_resp_rdata;
            end

            if (w_m1_ack) begin
                r_m1_err   <= r_err;
                r_m1_rdata <= w_resp_rdata;
            end
        end
    end

`ifdef DATA_RAM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_grant <= w_gnt;
        end
    end
`endif

    //------------------------------------------------------------------
    // Outputs: RAM read data is only valid during RESP, so the ack cycle
    // forwards it directly and the holding registers cover later cycles.
    //------------------------------------------------------------------
    assign m0_ack    = w_m0_ack;
    assign m0_err    = w_m0_ack ? r_err        : r_m0_err;
    assign m0_rdata  = w_m0_ack ? w_resp_rdata : r_m0_rdata;

    assign m1_ack    = w_m1_ack;
    assign m1_err    = w_m1_ack ? r_err        : r_m1_err;
    assign m1_rdata  = w_m1_ack ? w_resp_rdata : r_m1_rdata;

    assign busy      = (r_state != S_IDLE);
    assign err_count = r_err_count;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Testbench for data_ram_arbiter: directed accesses with a scoreboard of expected responses.
// Latency: checks the 2-cycle request-to-ack path and 3-cycle back-to-back cadence.
// Backpressure: exercises simultaneous requests, reset abort and error-counter saturation.

module tb_data_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rdata;
    logic        ram_en, ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        busy;
    logic [7:0]  err_count;

    int total;
    int bad;
    int exp_errs;

    typedef struct packed {
        logic        m;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    // Values seen on the RAM port in the first cycle after a request
    logic        s_en, s_we;
    logic [9:0]  s_addr;
    logic [31:0] s_wd;

    logic [31:0] mem [0:1023];

    data_ram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_err    (m0_err),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_err    (m1_err),
        .m1_rdata  (m1_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM model
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic m, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
        end
    endtask

    task automatic expect_resp(input logic m, input logic err, input logic [31:0] rd);
        exp_t e;
        e.m = m; e.err = err; e.rdata = rd;
        sb.push_back(e);
        if (err) exp_errs++;
    endtask

    task automatic wait_ack(input int exp_lat, input logic drop);
        int   n;
        exp_t e;
        logic got_m;
        int   sat;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                s_en = ram_en; s_we = ram_we; s_addr = ram_addr; s_wd = ram_wdata;
            end
        end while (!(m0_ack || m1_ack) && n < 8);
        if (!(m0_ack || m1_ack)) begin
            chk("ack_timeout", 32'(n), 32'(exp_lat));
            return;
        end
        if (sb.size() == 0) begin
            chk("unexpected_ack", 32'(sb.size()), 32'd1);
            return;
        end
        e     = sb.pop_front();
        got_m = m1_ack;
        sat   = (exp_errs > 255) ? 255 : exp_errs;
        chk("ack_master", 32'(got_m), 32'(e.m));
        chk("other_ack", 32'(m0_ack & m1_ack), 32'd0);
        chk("latency", 32'(n), 32'(exp_lat));
        chk("ack_err", 32'(got_m ? m1_err : m0_err), 32'(e.err));
        chk("ack_rdata", got_m ? m1_rdata : m0_rdata, e.rdata);
        chk("err_count", 32'(err_count), 32'(sat));
        if (drop) begin
            if (got_m) m1_req = 1'b0;
            else       m0_req = 1'b0;
        end
    endtask

    // One access from IDLE: request, wait 2 cycles for the ack, drop req.
    task automatic access(input logic m, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic err, input logic [31:0] rd);
        @(posedge clk); #1;
        drive(m, we, addr, wd);
        expect_resp(m, err, rd);
        wait_ack(2, 1'b1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_errs = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; exp_errs = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        ram_rdata = 32'h0;
        reset  = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_ram_en",    32'(ram_en), 32'd0);
        chk("rst_m0_ack",    32'(m0_ack), 32'd0);
        chk("rst_m1_ack",    32'(m1_ack), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_m0_rdata",  m0_rdata, 32'd0);
        reset = 1'b0;

        // m0 store to word 2
        access(1'b0, 1'b1, 32'h10010008, 32'hDEADBEEF, 1'b0, 32'h0);
        chk("st_ram_en",    32'(s_en), 32'd1);
        chk("st_ram_we",    32'(s_we), 32'd1);
        chk("st_ram_addr",  32'(s_addr), 32'd2);
        chk("st_ram_wdata", s_wd, 32'hDEADBEEF);

        // m0 load back
        access(1'b0, 1'b0, 32'h10010008, 32'h0, 1'b0, 32'hDEADBEEF);
        chk("ld_ram_we", 32'(s_we), 32'd0);

        // m1 misaligned load
        access(1'b1, 1'b0, 32'h10010006, 32'h0, 1'b1, 32'h0);
        chk("mis_ram_en", 32'(s_en), 32'd0);

        // m1 store to word 5
        access(1'b1, 1'b1, 32'h10010014, 32'h12345678, 1'b0, 32'h0);
        chk("m1_st_addr", 32'(s_addr), 32'd5);

        // Just past the top of RAM (index 1024)
        access(1'b0, 1'b1, 32'h10011000, 32'h55555555, 1'b1, 32'h0);
        chk("oor_ram_en", 32'(s_en), 32'd0);
        @(posedge clk); #1;
        chk("m0_err_hold", 32'(m0_err), 32'd1);

        // Last word of RAM (index 1023)
        access(1'b0, 1'b1, 32'h10010FFC, 32'hA5A5A5A5, 1'b0, 32'h0);
        chk("top_ram_en",   32'(s_en), 32'd1);
        chk("top_ram_addr", 32'(s_addr), 32'd1023);
        access(1'b1, 1'b0, 32'h10010FFC, 32'h0, 1'b0, 32'hA5A5A5A5);

        // Below base: wraps to a huge offset
        access(1'b0, 1'b0, 32'h1000FFFC, 32'h0, 1'b1, 32'h0);
        chk("below_ram_en", 32'(s_en), 32'd0);
        chk("m1_rdata_hold", m1_rdata, 32'hA5A5A5A5);

        // Reset asserted while in ACCESS aborts the access
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h10010008, 32'h0);
        @(posedge clk); #1;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        chk("abort_en_pre",   32'(ram_en), 32'd1);
        reset  = 1'b1;
        m0_req = 1'b0;
        @(posedge clk); #1;
        chk("abort_ram_en", 32'(ram_en), 32'd0);
        chk("abort_busy",   32'(busy), 32'd0);
        chk("abort_errcnt", 32'(err_count), 32'd0);
        chk("abort_m0_ack", 32'(m0_ack), 32'd0);
        chk("abort_m0_err", 32'(m0_err), 32'd0);
        reset = 1'b0;
        exp_errs = 0;
        @(posedge clk); #1;
        chk("abort_no_ack", 32'(m0_ack), 32'd0);

        // Normal load after the abort
        access(1'b0, 1'b0, 32'h10010008, 32'h0, 1'b0, 32'hDEADBEEF);

        // Both masters hold req for 4 grants
        pulse_reset();
        drive(1'b0, 1'b0, 32'h10010008, 32'h0);
        drive(1'b1, 1'b0, 32'h10010014, 32'h0);
`ifdef DATA_RAM_ARB_ROUND_ROBIN_EN
        expect_resp(1'b0, 1'b0, 32'hDEADBEEF);
        expect_resp(1'b1, 1'b0, 32'h12345678);
        expect_resp(1'b0, 1'b0, 32'hDEADBEEF);
        expect_resp(1'b1, 1'b0, 32'h12345678);
`else
        for (int i = 0; i < 4; i++) expect_resp(1'b0, 1'b0, 32'hDEADBEEF);
`endif
        wait_ack(2, 1'b0);
        for (int i = 0; i < 3; i++) wait_ack(3, 1'b0);
        m0_req = 1'b0;
        m1_req = 1'b0;

        // 300 misaligned accesses: counter saturates at 0xFF
        pulse_reset();
        for (int i = 0; i < 300; i++) begin
            access(1'b1, 1'b0, 32'h10010001, 32'h0, 1'b1, 32'h0);
        end
        chk("sat_err_count", 32'(err_count), 32'hFF);
        access(1'b0, 1'b0, 32'h10010003, 32'h0, 1'b1, 32'h0);
        chk("sat_hold", 32'(err_count), 32'hFF);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Sequences and shares the single-port MIPS data RAM between two requesters: m0 (CPU load/store unit) and m1 (auxiliary master, e.g. UART/DMA loader).
- Converts MIPS byte addresses in the data segment into RAM word indices and rejects misaligned or out-of-range accesses before the RAM is touched.
- Exactly one access is in flight at a time, with a fixed 2-cycle request-to-acknowledge latency.

Parameters:
- ADDR_WIDTH, 32, MIPS byte-address width.
- DATA_WIDTH, 32, data word width.
- BASE_ADDR, 32'h10010000, MIPS address of RAM word 0.
- RAM_AW, 10, RAM word-index width; RAM holds 2^RAM_AW words.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  m0 request; held high until m0_ack.
- m0_we  input  1  m0 write enable (1 = store, 0 = load).
- m0_addr  input  ADDR_WIDTH  m0 MIPS byte address.
- m0_wdata  input  DATA_WIDTH  m0 store data.
- m0_ack  output  1  one-cycle completion pulse to m0.
- m0_err  output  1  valid with m0_ack; 1 = access rejected.
- m0_rdata  output  DATA_WIDTH  load data, valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: identical to the m0 ports, for m1.
- ram_en  output  1  RAM access strobe.
- ram_we  output  1  RAM write strobe.
- ram_addr  output  RAM_AW  RAM word index.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_rdata  input  DATA_WIDTH  RAM read data; synchronous, valid the cycle after ram_en.
- busy  output  1  high whenever the FSM is not in IDLE.
- err_count  output  8  saturating count of rejected accesses.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, last_grant = 1 (so m0 wins the first tie). Reset mid-access aborts it: no ack is issued and ram_en deasserts the next cycle.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, cycle T, no request: stay in IDLE.
- IDLE, cycle T, any req: select a requester, latch its we/addr/wdata and grant id, compute the checks, go to ACCESS.
- Arbitration without the optional feature: fixed priority, m0 beats m1.
- Address translation: offset = addr - BASE_ADDR, modulo 2^ADDR_WIDTH. index = offset >> 2.
- Checks: misaligned = addr[1:0] != 0. out_of_range = (offset >> 2) >= 2^RAM_AW, unsigned. Addresses below BASE_ADDR wrap to large offsets and are therefore out of range.
- ACCESS, cycle T+1: if no error, drive ram_en = 1, ram_we = latched we, ram_addr = index[RAM_AW-1:0], ram_wdata = latched wdata. If error, keep ram_en = 0 and ram_we = 0. Go to RESP.
- RESP, cycle T+2: pulse the granted mX_ack for one cycle. mX_err = error flag. mX_rdata = ram_rdata for a good load, 0 for stores and errors. Return to IDLE.
- Latency is always 2 cycles from sampled req to ack, including error cases.
- The ungranted requester sees no ack. Its outputs stay 0.
- mX_rdata and mX_err hold their value until that master's next ack.
- Requesters must drop req the cycle after ack. A req still high in IDLE is served as a new request.
- Back-to-back: IDLE re-samples the cycle after RESP, giving at best one access per 3 cycles.
- err_count increments on each rejected access and saturates at 8'hFF.
- req edges while busy have no effect. Inputs are sampled only in IDLE.

Optional Feature:
- Macro: DATA_RAM_ARB_ROUND_ROBIN_EN.
- Defined: when both requesters assert req in IDLE, grant the one not equal to last_grant. last_grant updates on every grant, so simultaneous continuous requests alternate m0, m1, m0, ...
- Undefined: fixed priority, m0 always wins, m1 only served when m0_req = 0. last_grant is not implemented.

Test Plan:
- m0 store: addr 0x10010008, wdata 0xDEADBEEF; T+1 ram_en=1, ram_we=1, ram_addr=2. Then m0 load of the same address: m0_ack at T+2, m0_rdata=0xDEADBEEF, m0_err=0.
- Misaligned access: m1 load at 0x10010006 -> ram_en stays 0, m1_ack at T+2 with m1_err=1, err_count=1.
- Range checks with RAM_AW=10: address 0x10011000 (index 1024) -> err=1; 0x10010FFC -> index 1023, ok; 0x1000FFFC (below base) -> err=1.
- Simultaneous m0/m1 reads held for 4 grants: without the macro the sequence is m0,m0,m0,m0; with DATA_RAM_ARB_ROUND_ROBIN_EN it is m0,m1,m0,m1.
- Assert reset in ACCESS state: next cycle ram_en=0, no ack issued, busy=0, err_count=0. A subsequent m0 load completes normally.
- 300 misaligned requests -> err_count saturates at 0xFF and stays there.
